// File: rtl/data_sram_responder.sv
// data_sram_responder: slave end of the data-SRAM request/response interface.
// Accepts loads and stores, updates memory at acceptance, and returns in-order
// data_ok/rdata after a fixed latency through a small circular response queue.
// Optional build macro: DATA_SRAM_RAND_STALL_EN adds LFSR-driven random stalls
// on both addr_ok and data_ok for stressing the master's handshake logic.
module data_sram_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2,
  parameter int DEPTH      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);
  localparam logic [3:0]       TIMER_INIT = 4'(LATENCY - 1);

  logic [31:0]      mem_q [2**ADDR_WIDTH];

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] wr_q, wr_d;
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [3:0]       timer_q [DEPTH];
  logic [3:0]       timer_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  push, pop, head_ready;
  logic                  stall_accept, stall_resp;
  logic                  unused_in;

  // Size is informational only; byte lanes come from wstrb, and the upper
  // address bits alias so only the word index selects memory.
  assign unused_in = ^{data_sram_size, data_sram_addr[31:ADDR_WIDTH+2], data_sram_addr[1:0]};
  assign word_idx  = data_sram_addr[ADDR_WIDTH+1:2];

`ifdef DATA_SRAM_RAND_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR for x^16+x^14+x^13+x^11, stepping every cycle.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // LFSR register, reseeded on reset.
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end

  assign stall_accept = lfsr_q[0];
  assign stall_resp   = lfsr_q[1];
`else
  assign stall_accept = 1'b0;
  assign stall_resp   = 1'b0;
`endif

  // addr_ok looks only at registered occupancy, never at a same-cycle pop.
  assign data_sram_addr_ok = !reset && (count_q < DEPTH_CNT) && !stall_accept;
  assign head_ready        = valid_q[head_q] && (timer_q[head_q] == 4'd0);
  assign data_sram_data_ok = head_ready && !stall_resp;
  assign data_sram_rdata   = (data_sram_data_ok && !wr_q[head_q]) ? data_q[head_q] : 32'd0;

  assign push = data_sram_req && data_sram_addr_ok;
  assign pop  = data_sram_data_ok;

  // Queue next state: age timers, retire the head, append the new request.
  always_comb begin
    valid_d = valid_q;
    wr_d    = wr_q;
    data_d  = data_q;
    timer_d = timer_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (timer_q[i] != 4'd0)) timer_d[i] = timer_q[i] - 4'd1;
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d = (head_q == LAST_PTR) ? '0 : head_q + PTR_W'(1);
    end
    if (push) begin
      // The load value is read here, before this edge's memory write.
      valid_d[tail_q] = 1'b1;
      wr_d[tail_q]    = data_sram_wr;
      data_d[tail_q]  = data_sram_wr ? 32'd0 : mem_q[word_idx];
      timer_d[tail_q] = TIMER_INIT;
      tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue state register; reset drops every outstanding entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      wr_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]  <= 32'd0;
        timer_q[i] <= 4'd0;
      end
    end else begin
      valid_q <= valid_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      timer_q <= timer_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Store lanes are committed at acceptance; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (push && data_sram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wstrb[i]) mem_q[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

endmodule
